// File: rtl/norm_shift_ctrl.sv
// -----------------------------------------------------------------------------
// norm_shift_ctrl
//
// Sequencing controller for a W-bit load/shift register datapath. It drives the
// register's load, shift-left and shift-right strobes and watches the register's
// MSB/LSB taps.
//
// Operations, selected by mode and captured when start is accepted:
//   mode 0 : normalise. Load the operand, then shift left until the MSB is 1.
//            Report the number of left shifts and whether the operand was zero.
//   mode 1 : right shift. Load the operand, then shift right by shamt places.
//            Report the sticky OR of every bit that was shifted out.
//
// Ports
//   clk        in   1      single clock, rising-edge
//   rst        in   1      synchronous, active-high reset
//   start      in   1      begin an operation; only honoured while idle
//   mode       in   1      0 = normalise left, 1 = shift right by shamt
//   shamt      in   CNT_W  right-shift amount (mode 1)
//   msb_in     in   1      shift register MSB tap
//   lsb_in     in   1      shift register LSB tap
//   ld         out  1      load strobe to the shift register
//   shl_en     out  1      shift-left strobe
//   shr_en     out  1      shift-right strobe
//   busy       out  1      high whenever an operation is in progress
//   done       out  1      one-cycle completion pulse
//   shift_cnt  out  CNT_W  shifts performed by the last operation
//   zero       out  1      mode 0 result: operand was all zeros
//   sticky     out  1      mode 1 result: OR of the bits shifted out
//
// Results (shift_cnt, zero, sticky) stay stable from completion until the
// next operation is accepted.
// -----------------------------------------------------------------------------
module norm_shift_ctrl #(
    parameter int W     = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [CNT_W-1:0] shamt,
    input  logic             msb_in,
    input  logic             lsb_in,
    output logic             ld,
    output logic             shl_en,
    output logic             shr_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             zero,
    output logic             sticky
);

    // Largest number of left shifts a non-zero operand can need; reaching it
    // with the MSB still clear means the operand was zero.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_NORM = 3'd2,
        S_SHR  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           state_reg,  state_next;
    logic             mode_reg,   mode_next;
    logic [CNT_W-1:0] shamt_reg,  shamt_next;
    logic [CNT_W-1:0] cnt_reg,    cnt_next;
    logic             zero_reg,   zero_next;
    logic             sticky_reg, sticky_next;

    // -------------------------------------------------------------------------
    // State and result registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            mode_reg   <= 1'b0;
            shamt_reg  <= '0;
            cnt_reg    <= '0;
            zero_reg   <= 1'b0;
            sticky_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            mode_reg   <= mode_next;
            shamt_reg  <= shamt_next;
            cnt_reg    <= cnt_next;
            zero_reg   <= zero_next;
            sticky_reg <= sticky_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and strobe decode
    // -------------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        mode_next   = mode_reg;
        shamt_next  = shamt_reg;
        cnt_next    = cnt_reg;
        zero_next   = zero_reg;
        sticky_next = sticky_reg;
        ld          = 1'b0;
        shl_en      = 1'b0;
        shr_en      = 1'b0;
        done        = 1'b0;
        busy        = (state_reg != S_IDLE);

        case (state_reg)
            S_IDLE: begin
                // Operation parameters are captured only here, so start
                // pulses during an operation cannot disturb it.
                if (start) begin
                    state_next  = S_LOAD;
                    mode_next   = mode;
                    shamt_next  = shamt;
                    cnt_next    = '0;
                    zero_next   = 1'b0;
                    sticky_next = 1'b0;
                end
            end

            S_LOAD: begin
                ld = 1'b1;
                if (!mode_reg) begin
                    state_next = S_NORM;
                end else if (shamt_reg == '0) begin
                    state_next = S_DONE;
                end else begin
                    state_next = S_SHR;
                end
            end

            S_NORM: begin
                // msb_in comes straight from the shift register's output
                // flop, so gating the shift with it stays register-to-register
                // and stops exactly when the leading one reaches the MSB.
                if (msb_in) begin
                    state_next = S_DONE;
                end else if (cnt_reg == CNT_MAX) begin
                    state_next = S_DONE;
                    zero_next  = 1'b1;
                end else begin
                    shl_en   = 1'b1;
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end

            S_SHR: begin
                // lsb_in is the bit this strobe pushes out of the register.
                shr_en      = 1'b1;
                sticky_next = sticky_reg | lsb_in;
                cnt_next    = cnt_reg + CNT_ONE;
                // shamt_reg is non-zero here, so shamt_reg-1 cannot wrap.
                if (cnt_reg == (shamt_reg - CNT_ONE)) begin
                    state_next = S_DONE;
                end
            end

            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign shift_cnt = cnt_reg;
    assign zero      = zero_reg;
    assign sticky    = sticky_reg;

endmodule
